mult_reduce: RTL and testbench
==============================

MULT_REDUCE -- requirements
Module: mult_reduce

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset; all state changes on the rising edge of clock.
REQ-002 SHALL have port: clock  input  1  system clock.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: in_valid  input  1  partial-product set present on pp_0..pp_7 this cycle.
REQ-005 SHALL have ports: pp_0 .. pp_7  input  32 each  partial products from the preceding latch stage, two's complement.
REQ-006 SHALL have port: reg_input  input  32  side-band word travelling with the set.
REQ-007 SHALL have port: busy  output  1  reduction in progress; new sets not accepted.
REQ-008 SHALL have port: result  output  32  sum of the eight partial products, low 32 bits.
REQ-009 SHALL have port: reg_output  output  32  side-band word of the set that produced result.
REQ-010 SHALL have port: overflow  output  1  signed overflow occurred in any adder level of that set.
REQ-011 SHALL have port: result_rdy  output  1  one-cycle pulse; result, reg_output, overflow valid.

Function
REQ-012 SHALL implement states IDLE, L1, L2, L3; busy = 1 exactly in L1, L2, L3.
REQ-013 IDLE with in_valid=1 SHALL capture pp_0..pp_7 and reg_input into internal registers and go to L1; with in_valid=0 SHALL stay IDLE.
REQ-014 L1 SHALL form four 32-bit sums (pp0+pp1, pp2+pp3, pp4+pp5, pp6+pp7) and go to L2.
REQ-015 L2 SHALL form two sums (s01+s23, s45+s67) and go to L3.
REQ-016 L3 SHALL form the final sum, load result, reg_output, overflow, assert result_rdy for the next cycle, and go to IDLE.
REQ-017 Latency SHALL be fixed: set accepted at edge k -> result_rdy high for exactly the cycle after edge k+3.
REQ-018 All additions SHALL wrap modulo 2^32; overflow SHALL be the OR of signed overflow (operand signs equal, sum sign differs) across all seven adds of the set.
REQ-019 in_valid while busy=1 SHALL be ignored: no capture, no state change, no effect on the set in flight.
REQ-020 in_valid in the cycle result_rdy=1 (state IDLE) SHALL be accepted; sustained throughput one set per 4 cycles.
REQ-021 result, reg_output, overflow SHALL hold their values after the pulse until the next L3 completion.
REQ-022 result_rdy SHALL never be high two consecutive cycles.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE and clear busy, result, reg_output, overflow, result_rdy and all internal sum registers to 0.
REQ-024 reset SHALL take priority over in_valid and over any in-flight reduction; an aborted set SHALL produce no result_rdy.
REQ-025 After reset deasserts, the first in_valid SHALL be accepted on the very next edge.

Verification
REQ-026 Bench SHALL check reset: reset one cycle -> busy=0, result=0, reg_output=0, overflow=0, result_rdy=0.
REQ-027 Bench SHALL check basic sum: pp_i = i+1 (1..8), reg_input=0xA5A5A5A5, in_valid one cycle -> busy high 3 cycles, then result=36 (0x24), reg_output=0xA5A5A5A5, overflow=0, result_rdy one cycle.
REQ-028 Bench SHALL check signed/overflow: pp_0=pp_1=0x7FFFFFFF, others 0 -> result=0xFFFFFFFE, overflow=1; pp_0=0xFFFFFFFF (-1), pp_1=1, others 0 -> result=0, overflow=0.
REQ-029 Bench SHALL check in_valid ignored while busy: second set (all pp=0x10) asserted during L1..L3 -> only first set's result appears, no extra result_rdy.
REQ-030 Bench SHALL check back-to-back: second set (all pp=2) presented in the result_rdy cycle -> accepted, result=16 exactly 4 cycles after the first pulse.
REQ-031 Bench SHALL check reset mid-operation: reset in L2 -> IDLE next cycle, no result_rdy, outputs 0; following set completes normally.

Source files
------------

// File: rtl/mult_reduce.sv
// Three-level adder tree that sums eight captured partial products over three
// busy cycles, then presents the sum, the side-band word and a sticky overflow flag.
module mult_reduce (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] pp_0,
    input  logic [31:0] pp_1,
    input  logic [31:0] pp_2,
    input  logic [31:0] pp_3,
    input  logic [31:0] pp_4,
    input  logic [31:0] pp_5,
    input  logic [31:0] pp_6,
    input  logic [31:0] pp_7,
    input  logic [31:0] reg_input,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] reg_output,
    output logic        overflow,
    output logic        result_rdy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        L3   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pp_q [8];
    logic [31:0] reg_q;
    logic [31:0] s1_q [4];
    logic        ov1_q;
    logic [31:0] s2_q [2];
    logic        ov2_q;

    logic [31:0] s1_d [4];
    logic        ov1_d;
    logic [31:0] s2_d [2];
    logic        ov2_d;
    logic [31:0] fin_d;
    logic        ov3_d;

    // Signed overflow: both operands share a sign that the wrapped sum does not.
    function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    // Adder tree; the overflow flag accumulates level by level alongside the sums.
    always_comb begin
        ov1_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s1_d[i] = pp_q[2*i] + pp_q[2*i+1];
            ov1_d   = ov1_d | add_ovf(pp_q[2*i], pp_q[2*i+1], s1_d[i]);
        end
        ov2_d = ov1_q;
        for (int j = 0; j < 2; j++) begin
            s2_d[j] = s1_q[2*j] + s1_q[2*j+1];
            ov2_d   = ov2_d | add_ovf(s1_q[2*j], s1_q[2*j+1], s2_d[j]);
        end
        fin_d = s2_q[0] + s2_q[1];
        ov3_d = ov2_q | add_ovf(s2_q[0], s2_q[1], fin_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = L1;
            L1:   state_next = L2;
            L2:   state_next = L3;
            L3:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        dbg_state = state;
    end

    // Requests arriving outside IDLE are simply not looked at.
    always_ff @(posedge clock) begin
        if (reset) begin
            pp_q       <= '{default: '0};
            reg_q      <= '0;
            s1_q       <= '{default: '0};
            ov1_q      <= 1'b0;
            s2_q       <= '{default: '0};
            ov2_q      <= 1'b0;
            result     <= '0;
            reg_output <= '0;
            overflow   <= 1'b0;
            result_rdy <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pp_q  <= '{pp_0, pp_1, pp_2, pp_3, pp_4, pp_5, pp_6, pp_7};
                        reg_q <= reg_input;
                    end
                end
                L1: begin
                    s1_q  <= s1_d;
                    ov1_q <= ov1_d;
                end
                L2: begin
                    s2_q  <= s2_d;
                    ov2_q <= ov2_d;
                end
                L3: begin
                    result     <= fin_d;
                    reg_output <= reg_q;
                    overflow   <= ov3_d;
                    result_rdy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_reduce.sv
// Bench for mult_reduce: directed and random partial-product sets, an expected
// queue filled by the driver, and a negedge monitor that checks every cycle.
module tb_mult_reduce;

    typedef logic [31:0] set_t [8];

    typedef struct {
        logic [31:0] res;
        logic [31:0] regv;
        logic        ov;
        int          due;
    } exp_t;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -(64'sd2147483648);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] pp_in [8] = '{default: '0};
    logic [31:0] reg_input = '0;
    logic        busy;
    logic [31:0] result;
    logic [31:0] reg_output;
    logic        overflow;
    logic        result_rdy;
    logic [1:0]  dbg_state;

    exp_t        exp_q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          next_free = 0;
    int          last_k = -100;
    bit          mon_en = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] held_res = '0;
    logic [31:0] held_reg = '0;
    logic        held_ov = 1'b0;

    mult_reduce dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .pp_0       (pp_in[0]),
        .pp_1       (pp_in[1]),
        .pp_2       (pp_in[2]),
        .pp_3       (pp_in[3]),
        .pp_4       (pp_in[4]),
        .pp_5       (pp_in[5]),
        .pp_6       (pp_in[6]),
        .pp_7       (pp_in[7]),
        .reg_input  (reg_input),
        .busy       (busy),
        .result     (result),
        .reg_output (reg_output),
        .overflow   (overflow),
        .result_rdy (result_rdy),
        .dbg_state  (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, state=%0d", dbg_state);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: pairwise tree on true signed values, wrapping each level to 32 bits.
    function automatic void model(input set_t v, output logic [31:0] res, output logic ov);
        longint lvl [8];
        longint t;
        ov = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i] = longint'($signed(v[i]));
        for (int w = 8; w > 1; w = w / 2) begin
            for (int i = 0; i < w / 2; i++) begin
                t = lvl[2*i] + lvl[2*i+1];
                if (t > MAXV || t < MINV) ov = 1'b1;
                lvl[i] = longint'($signed(t[31:0]));
            end
        end
        t = lvl[0];
        res = t[31:0];
    endfunction

    // Driver tasks: each advances one edge, then updates inputs 1ns later.
    task automatic send(input set_t v, input logic [31:0] r);
        int k;
        logic [31:0] res;
        logic ov;
        @(posedge clock); #1;
        pp_in     = v;
        reg_input = r;
        in_valid  = 1'b1;
        k = cyc + 1;
        if (k >= next_free) begin
            model(v, res, ov);
            exp_q.push_back('{res, r, ov, k + 3});
            next_free = k + 4;
            last_k    = k;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        next_free = 0;
        last_k    = -100;
        held_res  = '0;
        held_reg  = '0;
        held_ov   = 1'b0;
        reset     = 1'b0;
    endtask

    function automatic set_t fill(input logic [31:0] x);
        set_t v;
        for (int i = 0; i < 8; i++) v[i] = x;
        return v;
    endfunction

    function automatic set_t rand_set();
        set_t v;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: v[i] = $urandom_range(0, 255);
                1: v[i] = 32'h7FFF_FF00 + $urandom_range(0, 255);
                2: v[i] = 32'h8000_0000 + $urandom_range(0, 255);
                default: v[i] = $urandom;
            endcase
        end
        return v;
    endfunction

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (mon_en) begin
            check("busy", busy, (cyc >= last_k && cyc <= last_k + 2));
            if (result_rdy) begin
                check("rdy_consecutive", prev_rdy, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: result_rdy=1 with nothing in flight (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rdy_cycle", cyc, e.due);
                    check("result", result, e.res);
                    check("reg_output", reg_output, e.regv);
                    check("overflow", overflow, e.ov);
                    held_res = e.res;
                    held_reg = e.regv;
                    held_ov  = e.ov;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_rdy: result_rdy=0, expected pulse at cycle %0d (now %0d)",
                             exp_q[0].due, cyc);
                    void'(exp_q.pop_front());
                end
                check("hold_result", result, held_res);
                check("hold_reg_output", reg_output, held_reg);
                check("hold_overflow", overflow, held_ov);
            end
            prev_rdy = result_rdy;
        end
    end

    initial begin
        set_t v;
        // Initial reset.
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic sum 1..8.
        for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
        send(v, 32'hA5A5_A5A5);
        idle(6);

        // Signed overflow, then -1 + 1.
        v = fill(32'h0);
        v[0] = 32'h7FFF_FFFF;
        v[1] = 32'h7FFF_FFFF;
        send(v, 32'h1111_1111);
        idle(6);
        v = fill(32'h0);
        v[0] = 32'hFFFF_FFFF;
        v[1] = 32'h0000_0001;
        send(v, 32'h2222_2222);
        idle(6);

        // Requests while busy must be ignored.
        send(rand_set(), 32'h3333_3333);
        send(fill(32'h10), 32'hDEAD_0001);
        send(fill(32'h10), 32'hDEAD_0002);
        send(fill(32'h10), 32'hDEAD_0003);
        idle(8);

        // Back-to-back: second set presented in the result_rdy cycle.
        send(rand_set(), 32'h4444_4444);
        idle(3);
        send(fill(32'h2), 32'h5555_5555);
        idle(8);

        // Reset while in L2, then a normal set.
        send(rand_set(), 32'h6666_6666);
        idle(1);
        do_reset();
        send(rand_set(), 32'h7777_7777);
        idle(6);

        // Random traffic with occasional resets.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            send(rand_set(), $urandom);
            idle($urandom_range(0, 4));
        end

        idle(8);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
